// File: rtl/pzcorebus_outstanding_tracker.sv
// pzcorebus_outstanding_tracker: per-slot outstanding non-posted command
// throttle with unexpected-response detection and response watchdog.
module pzcorebus_outstanding_tracker #(
   parameter int ID_WIDTH       = 8,
   parameter int SLOT_WIDTH     = 2,
   parameter int MAX_PER_SLOT   = 4,
   parameter int MAX_TOTAL      = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int COUNT_WIDTH    = $clog2(MAX_TOTAL + 1)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_command_valid,
   output logic                   o_command_accept,
   output logic                   o_command_valid,
   input  logic                   i_command_accept,
   input  logic [3:0]             i_command_type,
   input  logic [ID_WIDTH-1:0]    i_command_id,
   input  logic                   i_response_valid,
   input  logic                   i_response_accept,
   input  logic [ID_WIDTH-1:0]    i_response_id,
   input  logic [1:0]             i_response_last,
   input  logic                   i_clear,
   output logic [COUNT_WIDTH-1:0] o_outstanding_count,
   output logic                   o_idle,
   output logic                   o_unexpected_response,
   output logic                   o_error,
   output logic                   o_timeout
);

   localparam int NSLOT = 1 << SLOT_WIDTH;
   localparam int PW    = $clog2(MAX_PER_SLOT + 1);

   logic [PW-1:0]          cnt_q [NSLOT];
   logic [PW-1:0]          cnt_d [NSLOT];
   logic [COUNT_WIDTH-1:0] total_q;
   logic [COUNT_WIDTH-1:0] total_d;
   logic                   unexp_q;
   logic                   err_q;
   logic                   err_d;
   logic                   tmo_q;
   logic                   tmo_d;
   logic                   idle_q;
   logic                   idle_d;

   logic [SLOT_WIDTH-1:0]  slot_c;
   logic [SLOT_WIDTH-1:0]  slot_r;
   logic                   np;
   logic                   stall;
   logic                   cmd_fire;
   logic                   rsp_fire;
   logic                   unexp;
   logic                   rsp_hit;
   logic                   tmo_set;
   logic                   unused_bits;

   assign np     = i_command_type[3];
   assign slot_c = i_command_id[SLOT_WIDTH-1:0];
   assign slot_r = i_response_id[SLOT_WIDTH-1:0];

   assign stall = np && (cnt_q[slot_c] == PW'(MAX_PER_SLOT) ||
                         total_q == COUNT_WIDTH'(MAX_TOTAL));

   assign o_command_valid  = i_command_valid & ~stall;
   assign o_command_accept = i_command_accept & ~stall;

   assign cmd_fire = i_command_valid & o_command_accept & np;
   assign rsp_fire = i_response_valid & i_response_accept & i_response_last[0];

   // Zero check uses registered count, so a same-cycle command cannot cover it
   assign unexp   = rsp_fire && (cnt_q[slot_r] == '0);
   assign rsp_hit = rsp_fire && !unexp;

   always_comb begin
      for (int s = 0; s < NSLOT; s++) begin
         cnt_d[s] = cnt_q[s];
         if (cmd_fire && slot_c == SLOT_WIDTH'(s)) begin
            cnt_d[s] = cnt_d[s] + PW'(1);
         end
         if (rsp_hit && slot_r == SLOT_WIDTH'(s)) begin
            cnt_d[s] = cnt_d[s] - PW'(1);
         end
      end
      total_d = total_q + COUNT_WIDTH'(cmd_fire) - COUNT_WIDTH'(rsp_hit);
      idle_d  = (total_d == '0);
      err_d   = unexp | (err_q & ~i_clear);
      tmo_d   = tmo_set | (tmo_q & ~i_clear);
   end

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_wd
         localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
         logic [WW-1:0] wd_q;
         logic [WW-1:0] wd_d;
         logic          wd_inc;

         always_comb begin
            wd_d   = wd_q;
            wd_inc = 1'b0;
            if (rsp_fire || total_q == '0) begin
               wd_d = '0;
            end else if (wd_q != WW'(TIMEOUT_CYCLES)) begin
               wd_inc = 1'b1;
               wd_d   = wd_q + WW'(1);
            end
         end

         assign tmo_set = wd_inc && (wd_q == WW'(TIMEOUT_CYCLES - 1));

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               wd_q <= '0;
            end else begin
               wd_q <= wd_d;
            end
         end
      end else begin : g_nowd
         assign tmo_set = 1'b0;
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int s = 0; s < NSLOT; s++) begin
            cnt_q[s] <= '0;
         end
         total_q <= '0;
         unexp_q <= 1'b0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
         idle_q  <= 1'b1;
      end else begin
         for (int s = 0; s < NSLOT; s++) begin
            cnt_q[s] <= cnt_d[s];
         end
         total_q <= total_d;
         unexp_q <= unexp;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
         idle_q  <= idle_d;
      end
   end

   assign o_outstanding_count   = total_q;
   assign o_idle                = idle_q;
   assign o_unexpected_response = unexp_q;
   assign o_error               = err_q;
   assign o_timeout             = tmo_q;

   assign unused_bits = ^{i_command_type[2:0], i_command_id,
                          i_response_id, i_response_last[1]};

endmodule

// File: tb/tb_pzcorebus_outstanding_tracker.sv
// Bench for pzcorebus_outstanding_tracker: directed scenarios plus random
// traffic against a per-slot counting reference model.
module tb_pzcorebus_outstanding_tracker;

   localparam int IDW = 8;
   localparam int SW  = 2;
   localparam int NS  = 4;
   localparam int MPS = 4;
   localparam int MT  = 8;
   localparam int TO  = 16;
   localparam int CW  = $clog2(MT + 1);

   logic           clk = 1'b0;
   logic           rst;
   logic           cv;
   logic           ca;
   logic [3:0]     typ;
   logic [IDW-1:0] cid;
   logic           rv;
   logic           ra;
   logic [IDW-1:0] rid;
   logic [1:0]     rl;
   logic           clr;
   logic           o_cv;
   logic           o_ca;
   logic [CW-1:0]  o_cnt;
   logic           o_idle;
   logic           o_unx;
   logic           o_err;
   logic           o_tmo;

   int n_cmp = 0;
   int n_bad = 0;

   int m_cnt [NS];
   int m_tot;
   int m_quiet;
   bit m_err;
   bit m_tmo;
   bit m_unx;

   always #5 clk = ~clk;

   pzcorebus_outstanding_tracker #(
      .ID_WIDTH      (IDW),
      .SLOT_WIDTH    (SW),
      .MAX_PER_SLOT  (MPS),
      .MAX_TOTAL     (MT),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk                (clk),
      .i_rst                (rst),
      .i_command_valid      (cv),
      .o_command_accept     (o_ca),
      .o_command_valid      (o_cv),
      .i_command_accept     (ca),
      .i_command_type       (typ),
      .i_command_id         (cid),
      .i_response_valid     (rv),
      .i_response_accept    (ra),
      .i_response_id        (rid),
      .i_response_last      (rl),
      .i_clear              (clr),
      .o_outstanding_count  (o_cnt),
      .o_idle               (o_idle),
      .o_unexpected_response(o_unx),
      .o_error              (o_err),
      .o_timeout            (o_tmo)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic quiet_in();
      rst = 0; cv = 0; ca = 0; typ = 4'h0; cid = '0;
      rv = 0; ra = 0; rid = '0; rl = 2'b00; clr = 0;
   endtask

   // Called with inputs settled just after a negedge; returns at next negedge
   task automatic step();
      bit np, stall, cf, rf, unx;
      int sc, sr;
      #1;
      np = typ[3];
      sc = int'(cid) % NS;
      sr = int'(rid) % NS;
      stall = np && (m_cnt[sc] >= MPS || m_tot >= MT);
      chk("cmd_valid", 32'(o_cv), 32'(cv && !stall));
      chk("cmd_accept", 32'(o_ca), 32'(ca && !stall));
      cf  = cv && ca && !stall && np;
      rf  = rv && ra && rl[0];
      unx = rf && (m_cnt[sr] == 0);
      @(posedge clk);
      if (rst) begin
         foreach (m_cnt[s]) m_cnt[s] = 0;
         m_tot = 0; m_quiet = 0;
         m_err = 0; m_tmo = 0; m_unx = 0;
      end else begin
         if (rf || m_tot == 0) begin
            m_quiet = 0;
         end else begin
            m_quiet++;
         end
         if (clr) begin
            m_err = 0;
            m_tmo = 0;
         end
         if (m_quiet == TO) m_tmo = 1;
         if (unx) m_err = 1;
         m_unx = unx;
         if (cf) begin
            m_cnt[sc]++;
            m_tot++;
         end
         if (rf && !unx) begin
            m_cnt[sr]--;
            m_tot--;
         end
      end
      #1;
      chk("count", 32'(o_cnt), 32'(m_tot));
      chk("idle", 32'(o_idle), 32'(m_tot == 0));
      chk("unexp", 32'(o_unx), 32'(m_unx));
      chk("error", 32'(o_err), 32'(m_err));
      chk("timeout", 32'(o_tmo), 32'(m_tmo));
      @(negedge clk);
   endtask

   task automatic read(input int id);
      quiet_in();
      cv = 1; ca = 1; typ = 4'b1001; cid = IDW'(id);
      step();
   endtask

   task automatic resp(input int id, input logic [1:0] last);
      quiet_in();
      rv = 1; ra = 1; rid = IDW'(id); rl = last;
      step();
   endtask

   task automatic drain();
      for (int s = 0; s < NS; s++) begin
         while (m_cnt[s] > 0) resp(s, 2'b01);
      end
      quiet_in();
      clr = 1;
      step();
      quiet_in();
   endtask

   initial begin
      foreach (m_cnt[s]) m_cnt[s] = 0;
      m_tot = 0; m_quiet = 0; m_err = 0; m_tmo = 0; m_unx = 0;
      quiet_in();
      rst = 1;
      @(negedge clk);
      step();
      chk("rst_idle", 32'(o_idle), 32'd1);
      chk("rst_count", 32'(o_cnt), 32'd0);
      quiet_in();

      // Per-slot limit on slot 1
      for (int i = 0; i < 4; i++) read(1);
      chk("slot1_full", 32'(o_cnt), 32'd4);
      read(1);
      quiet_in();
      cv = 1; ca = 1; typ = 4'b1001; cid = 8'h01;
      rv = 1; ra = 1; rid = 8'h01; rl = 2'b01;
      step();
      read(1);
      chk("slot1_refill", 32'(o_cnt), 32'd4);
      drain();

      // Global limit, posted bypass
      for (int s = 0; s < NS; s++) begin
         read(s);
         read(s);
      end
      read(0);
      quiet_in();
      cv = 1; ca = 1; typ = 4'b0100; cid = 8'h00;
      step();
      chk("posted_pass", 32'(o_cnt), 32'd8);
      drain();

      // Same-slot command and response
      read(2);
      quiet_in();
      cv = 1; ca = 1; typ = 4'b1001; cid = 8'h06;
      rv = 1; ra = 1; rid = 8'h02; rl = 2'b01;
      step();
      chk("same_slot", 32'(o_cnt), 32'd1);
      drain();

      // Unexpected response, non-final beats
      resp(3, 2'b01);
      quiet_in();
      step();
      read(3);
      resp(3, 2'b00);
      resp(3, 2'b10);
      chk("nonfinal", 32'(o_cnt), 32'd1);
      quiet_in();
      clr = 1;
      step();
      drain();

      // Watchdog
      read(1);
      quiet_in();
      for (int i = 0; i < TO + 2; i++) step();
      chk("wd_fired", 32'(o_tmo), 32'd1);
      quiet_in();
      clr = 1; rv = 1; ra = 1; rid = 8'h01; rl = 2'b01;
      step();
      chk("wd_cleared", 32'(o_tmo), 32'd0);
      drain();

      // Reset mid-operation
      read(2); read(2); read(2);
      quiet_in();
      rst = 1;
      step();
      resp(2, 2'b01);
      chk("post_rst_err", 32'(o_err), 32'd1);
      drain();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bit quiet;
         quiet = ((i / 60) % 4) == 3;
         rst = ($urandom_range(0, 599) == 0);
         cv  = 1'($urandom);
         ca  = ($urandom_range(0, 3) != 0);
         typ = 4'($urandom);
         cid = IDW'($urandom);
         rv  = quiet ? 1'b0 : 1'($urandom);
         ra  = ($urandom_range(0, 3) != 0);
         rid = IDW'($urandom);
         rl  = 2'($urandom);
         clr = ($urandom_range(0, 31) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
